// File: rtl/load_store_unit.sv
// Load/store unit for the MEM stage. Translates byte-addressed requests into
// word accesses on a word-addressed data memory, doing read-modify-write for
// sub-word stores and lane select plus sign/zero extension for loads.
module load_store_unit #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              stall,
  output logic              access_error
);

  typedef enum logic [1:0] {StIdle, StLoadWait, StRmw, StDone} state_e;

  state_e      state_q, state_d;
  logic        was_load_q, was_load_d;
  logic        was_err_q, was_err_d;
  logic [31:0] load_data_q, load_data_d;

  logic        req_err;
  logic [4:0]  lane_shift;
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic        we_raw, re_raw, stall_raw, valid_raw, err_raw;

  assign mem_address = req_addr[ADDR_W+1:2];
  assign lane_shift  = {req_addr[1:0], 3'b000};

  // Reject reserved size, misaligned half/word and simultaneous read+write.
  always_comb begin
    req_err = 1'b0;
    unique case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if (req_read && req_write) req_err = 1'b1;
  end

  // Load lane select and extension; store lane merge over the old word.
  always_comb begin
    rdata_shifted = mem_rdata >> lane_shift;
    load_ext      = mem_rdata;
    lane_mask     = 32'hFFFF_FFFF;
    unique case (req_size)
      2'b00: begin
        load_ext  = {{24{~req_unsigned & rdata_shifted[7]}}, rdata_shifted[7:0]};
        lane_mask = 32'h0000_00FF << lane_shift;
      end
      2'b01: begin
        load_ext  = {{16{~req_unsigned & rdata_shifted[15]}}, rdata_shifted[15:0]};
        lane_mask = 32'h0000_FFFF << lane_shift;
      end
      default: begin
        load_ext  = mem_rdata;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
    merged = (mem_rdata & ~lane_mask) | ((req_wdata << lane_shift) & lane_mask);
  end

  // Next-state and raw output decode.
  always_comb begin
    state_d     = state_q;
    was_load_d  = was_load_q;
    was_err_d   = was_err_q;
    load_data_d = load_data_q;
    mem_wdata   = req_wdata;
    we_raw      = 1'b0;
    re_raw      = 1'b0;
    stall_raw   = 1'b0;
    valid_raw   = 1'b0;
    err_raw     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_read || req_write) begin
          was_load_d = 1'b0;
          was_err_d  = 1'b0;
          if (req_err) begin
            stall_raw = 1'b1;
            was_err_d = 1'b1;
            state_d   = StDone;
          end else if (req_read) begin
            re_raw     = 1'b1;
            stall_raw  = 1'b1;
            was_load_d = 1'b1;
            state_d    = StLoadWait;
          end else if (req_size == 2'b10) begin
            // Full-word store writes on this cycle's falling edge, no stall.
            we_raw = 1'b1;
          end else begin
            re_raw    = 1'b1;
            stall_raw = 1'b1;
            state_d   = StRmw;
          end
        end
      end
      StLoadWait: begin
        stall_raw   = 1'b1;
        load_data_d = load_ext;
        state_d     = StDone;
      end
      StRmw: begin
        stall_raw = 1'b1;
        we_raw    = 1'b1;
        mem_wdata = merged;
        state_d   = StDone;
      end
      StDone: begin
        valid_raw = was_load_q;
        err_raw   = was_err_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset gates the enables so no falling-edge write happens in a reset cycle.
  always_comb begin
    mem_we       = we_raw & ~reset;
    mem_re       = re_raw & ~reset;
    stall        = stall_raw & ~reset;
    load_valid   = valid_raw & ~reset;
    access_error = err_raw & ~reset;
    load_data    = load_data_q;
  end

  // State and load result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      was_load_q  <= 1'b0;
      was_err_q   <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      was_load_q  <= was_load_d;
      was_err_q   <= was_err_d;
      load_data_q <= load_data_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a behavioural data memory plus a byte-array
// reference model predicting latency, stall, pulses and load results.
module tb_load_store_unit;

  localparam int unsigned AW = 13;

  typedef struct packed {
    logic [3:0]  cycles;
    logic [3:0]  stalls;
    logic [1:0]  valid_n;
    logic [1:0]  err_n;
    logic [1:0]  we_n;
    logic [1:0]  re_n;
    logic [31:0] data;
  } res_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_read, req_write, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_wdata, mem_rdata, load_data;
  logic          mem_we, mem_re, load_valid, stall, access_error;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] tb_mem [0:(1<<AW)-1];
  logic [7:0]  ref_bytes [0:(1<<(AW+2))-1];
  logic [31:0] last_load;

  load_store_unit #(.ADDR_W(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .stall        (stall),
    .access_error (access_error)
  );

  always #5 clock = ~clock;

  // Data memory: writes on falling edge, registered read on rising edge.
  always @(negedge clock) if (mem_we) tb_mem[mem_address] <= mem_wdata;
  always @(posedge clock) if (mem_re) mem_rdata <= tb_mem[mem_address];

  function automatic logic [31:0] ref_word(input logic [AW+1:0] a);
    logic [AW+1:0] b;
    b = {a[AW+1:2], 2'b00};
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  // Reference: what the spec says each request should do, from byte-level rules.
  task automatic model(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [AW+1:0] a, input logic [31:0] wd, output res_t e);
    logic        err;
    int          nb;
    logic [31:0] v;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (rd && wr);
    nb  = 1 << sz;
    e   = '0;
    if (err) begin
      e.cycles = 2; e.stalls = 1; e.err_n = 1;
    end else if (rd) begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[a + i]) << (8 * i));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      last_load = v;
      e.cycles = 3; e.stalls = 2; e.valid_n = 1; e.re_n = 1;
    end else begin
      for (int i = 0; i < nb; i++) ref_bytes[a + i] = wd[8*i +: 8];
      if (nb == 4) begin
        e.cycles = 1; e.we_n = 1;
      end else begin
        e.cycles = 3; e.stalls = 2; e.we_n = 1; e.re_n = 1;
      end
    end
    e.data = last_load;
  endtask

  // Drive one request (entered #1 after a rising edge) and measure until it advances.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [AW+1:0] a, input logic [31:0] wd,
                            output res_t r);
    bit adv;
    r = '0;
    req_read = rd; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    adv = 0;
    for (int c = 0; c < 10 && !adv; c++) begin
      @(negedge clock);
      r.cycles = r.cycles + 1;
      if (stall)        r.stalls  = r.stalls + 1;
      if (load_valid)   r.valid_n = r.valid_n + 1;
      if (access_error) r.err_n   = r.err_n + 1;
      if (mem_we)       r.we_n    = r.we_n + 1;
      if (mem_re)       r.re_n    = r.re_n + 1;
      r.data = load_data;
      adv = !stall;
      @(posedge clock);
      #1;
    end
    if (!adv) r.cycles = 4'hF;
    req_read = 0; req_write = 0;
  endtask

  task automatic test_reset;
    logic [36:0] got;
    reset = 1; req_read = 1; req_size = 2'd2; req_addr = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    got = {stall, load_valid, access_error, mem_we, mem_re, load_data};
    vectors++;
    if (got !== 37'h0) begin
      miscompares++; $display("FAIL reset_gating got=%h exp=0", got);
    end
    @(posedge clock); #1;
    reset = 0; req_read = 0;
    last_load = 0;
    @(negedge clock);
    got = {stall, load_valid, access_error, mem_we, mem_re, load_data};
    vectors++;
    if (got !== 37'h0) begin
      miscompares++; $display("FAIL reset_idle got=%h exp=0", got);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_word_store_load;
    res_t e, g;
    model(0, 1, 2'd2, 0, 'h010, 32'hDEADBEEF, e); run_access(0, 1, 2'd2, 0, 'h010, 32'hDEADBEEF, g);
    vectors++;
    if (g !== e) begin miscompares++; $display("FAIL word_store got=%h exp=%h", g, e); end
    model(1, 0, 2'd2, 0, 'h010, 0, e); run_access(1, 0, 2'd2, 0, 'h010, 0, g);
    vectors++;
    if (g !== e || g.data !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL word_load got=%h exp=%h", g, e);
    end
  endtask

  task automatic test_byte_rmw;
    res_t e, g;
    model(0, 1, 2'd2, 0, 'h020, 32'h11223344, e); run_access(0, 1, 2'd2, 0, 'h020, 32'h11223344, g);
    model(0, 1, 2'd0, 0, 'h022, 32'h000000AA, e); run_access(0, 1, 2'd0, 0, 'h022, 32'h000000AA, g);
    vectors++;
    if (g !== e) begin miscompares++; $display("FAIL byte_store got=%h exp=%h", g, e); end
    vectors++;
    if (tb_mem['h020 >> 2] !== ref_word('h020)) begin
      miscompares++; $display("FAIL rmw_mem got=%h exp=%h", tb_mem['h020 >> 2], ref_word('h020));
    end
    model(1, 0, 2'd2, 0, 'h020, 0, e); run_access(1, 0, 2'd2, 0, 'h020, 0, g);
    vectors++;
    if (g !== e || g.data !== 32'h11AA3344) begin
      miscompares++; $display("FAIL rmw_load got=%h exp=%h", g, e);
    end
  endtask

  task automatic test_extension;
    logic [AW+1:0] ta [5] = '{'h033, 'h033, 'h030, 'h030, 'h032};
    logic [1:0]    ts [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    logic          tu [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0]   tx [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00000001, 32'h00007F01, 32'hFFFF80FF};
    res_t e, g;
    model(0, 1, 2'd2, 0, 'h030, 32'h80FF7F01, e); run_access(0, 1, 2'd2, 0, 'h030, 32'h80FF7F01, g);
    for (int i = 0; i < 5; i++) begin
      model(1, 0, ts[i], tu[i], ta[i], 0, e); run_access(1, 0, ts[i], tu[i], ta[i], 0, g);
      vectors++;
      if (g !== e || g.data !== tx[i]) begin
        miscompares++; $display("FAIL extend_%0d got=%h exp=%h const=%h", i, g, e, tx[i]);
      end
    end
  endtask

  task automatic test_errors;
    logic          tr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic          tw [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0]    ts [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
    logic [AW+1:0] ta [5] = '{'h041, 'h046, 'h040, 'h040, 'h040};
    res_t e, g;
    for (int i = 0; i < 5; i++) begin
      model(tr[i], tw[i], ts[i], 0, ta[i], 32'hBEEF, e);
      run_access(tr[i], tw[i], ts[i], 0, ta[i], 32'hBEEF, g);
      vectors++;
      if (g !== e || g.err_n !== 2'd1 || g.we_n !== 2'd0) begin
        miscompares++; $display("FAIL error_%0d got=%h exp=%h", i, g, e);
      end
    end
    vectors++;
    if (tb_mem['h040 >> 2] !== 32'h0) begin
      miscompares++; $display("FAIL error_mem got=%h exp=0", tb_mem['h040 >> 2]);
    end
  endtask

  task automatic test_reset_in_rmw;
    res_t e, g;
    logic [36:0] got;
    model(0, 1, 2'd2, 0, 'h050, 32'hCAFEF00D, e); run_access(0, 1, 2'd2, 0, 'h050, 32'hCAFEF00D, g);
    req_write = 1; req_size = 2'd1; req_unsigned = 0; req_addr = 'h052; req_wdata = 32'h1234;
    @(posedge clock); #1;
    reset = 1;
    @(negedge clock);
    vectors++;
    if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_rmw_we got=%b exp=0", mem_we); end
    @(posedge clock); #1;
    reset = 0; req_write = 0;
    last_load = 0;
    @(negedge clock);
    got = {stall, load_valid, access_error, mem_we, mem_re, load_data};
    vectors++;
    if (got !== 37'h0) begin miscompares++; $display("FAIL rst_rmw_out got=%h exp=0", got); end
    vectors++;
    if (tb_mem['h050 >> 2] !== 32'hCAFEF00D) begin
      miscompares++; $display("FAIL rst_rmw_mem got=%h exp=cafef00d", tb_mem['h050 >> 2]);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back;
    res_t e, g;
    logic [AW+1:0] top;
    top = '1; top[1:0] = 2'b00;
    model(0, 1, 2'd2, 0, top, 32'hA5A5_0001, e); run_access(0, 1, 2'd2, 0, top, 32'hA5A5_0001, g);
    vectors++;
    if (g !== e) begin miscompares++; $display("FAIL b2b_top got=%h exp=%h", g, e); end
    model(0, 1, 2'd2, 0, 'h000, 32'h5A5A_0002, e); run_access(0, 1, 2'd2, 0, 'h000, 32'h5A5A_0002, g);
    vectors++;
    if (g !== e) begin miscompares++; $display("FAIL b2b_zero got=%h exp=%h", g, e); end
    @(negedge clock);
    vectors++;
    if (tb_mem[top >> 2] !== ref_word(top) || tb_mem[0] !== ref_word('h000)) begin
      miscompares++;
      $display("FAIL b2b_mem got=%h/%h exp=%h/%h", tb_mem[top >> 2], tb_mem[0],
               ref_word(top), ref_word('h000));
    end
    @(posedge clock); #1;
  endtask

  task automatic test_random;
    res_t e, g;
    logic rd, wr, uns;
    logic [1:0] sz;
    logic [AW+1:0] a;
    logic [31:0] wd;
    int op;
    for (int i = 0; i < 80; i++) begin
      op  = int'($urandom_range(0, 9));
      rd  = (op < 5) || (op == 9);
      wr  = (op >= 5);
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      a   = (AW + 2)'($urandom_range(0, 63));
      if (op == 8) a = (AW + 2)'($urandom_range(0, (1 << (AW + 2)) - 1));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      wd = $urandom;
      model(rd, wr, sz, uns, a, wd, e);
      run_access(rd, wr, sz, uns, a, wd, g);
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL random_%0d rd=%b wr=%b sz=%0d a=%h got=%h exp=%h", i, rd, wr, sz, a, g, e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) tb_mem[i] = 32'h0;
    for (int i = 0; i < (1 << (AW + 2)); i++) ref_bytes[i] = 8'h0;
    last_load = 0;
    mem_rdata = 0;
    reset = 1; req_read = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    req_addr = '0; req_wdata = 0;
    @(posedge clock); #1;
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_extension();
    test_errors();
    test_reset_in_rmw();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits in the MEM stage, directly upstream of the word-addressed data memory.
- Takes byte-addressed load/store requests from the EX/MEM register and drives the data memory's address, write data, write enable and read enable.
- Handles byte, halfword and word sizes, including read-modify-write for sub-word stores and sign/zero extension for loads.
- Stalls the pipeline while a multi-cycle access is in flight.

Parameters:
ADDR_W, 11, word-address width of data memory; byte address is ADDR_W+2 bits

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_addr  in  ADDR_W+2  byte address of access
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_read  in  1  load request
req_write  in  1  store request
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
mem_address  out  ADDR_W  word address to data memory (req_addr[ADDR_W+1:2])
mem_wdata  out  32  write data to data memory
mem_we  out  1  data memory write enable (memory writes on falling edge)
mem_re  out  1  data memory read enable (memory registers on rising edge)
mem_rdata  in  32  data memory read data, valid the cycle after mem_re
load_data  out  32  extended load result, registered
load_valid  out  1  one-cycle pulse, load_data valid
stall  out  1  hold the pipeline; the request must stay stable while high
access_error  out  1  one-cycle pulse, request rejected

Behaviour:
- Little-endian byte lanes: lane k = bits [8k+7:8k], k = req_addr[1:0]. Half lane = req_addr[1].
- Error condition (checked in IDLE):
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - req_read and req_write both 1.
- FSM states: IDLE, LOAD_WAIT, RMW, DONE.
- IDLE, no request: mem_re=0, mem_we=0, stall=0.
- IDLE, error: no memory access, stall=1, next state DONE with access_error=1.
- IDLE, word store:
  - mem_we=1, mem_wdata=req_wdata, stall=0.
  - Write completes on that cycle's falling edge.
  - Stays in IDLE; back-to-back word stores run one per cycle.
- IDLE, load: mem_re=1, stall=1, next state LOAD_WAIT.
- IDLE, byte/half store: mem_re=1, stall=1, next state RMW.
- LOAD_WAIT:
  - mem_rdata valid. Select lane, extend per req_unsigned, register into load_data.
  - stall=1, mem_re=0, next state DONE.
- RMW:
  - mem_rdata valid. Replace the selected lane with req_wdata[7:0] or [15:0]; all other bits are preserved.
  - Drive mem_we=1 with the merged word; stall=1; next state DONE.
- DONE:
  - stall=0; load_valid=1 if the access was a load; access_error=1 if it was an error.
  - No memory enables. Next state IDLE; the pipeline advances at this edge.
  - A request presented in the following IDLE cycle is new.
- Latency:
  - load: 3 cycles request-to-advance, stall 2 cycles;
  - sub-word store: 3 cycles, stall 2;
  - word store: 1 cycle, no stall;
  - error: 2 cycles, stall 1.
- Reset values: state IDLE; load_data=0; load_valid=0; access_error=0; stall=0.
- mem_we and mem_re are gated to 0 combinationally while reset=1, so no falling-edge write occurs in a reset cycle.
- Reset in LOAD_WAIT or RMW abandons the access; memory is unmodified.
- Address wrap: the top word address 2^ADDR_W-1 is legal; there is no wrap handling beyond the address width.
- load_data holds its value until the next load completes.

Test Plan:
- Word store 0xDEADBEEF @0x010, then word load @0x010 -> one-cycle store with no stall; load: stall 2 cycles, load_valid in cycle 3, load_data=0xDEADBEEF.
- Word 0x11223344 @0x020, byte store 0xAA @0x022, word load @0x020 -> mem_we only in RMW cycle; load_data=0x11AA3344.
- Word 0x80FF7F01 @0x030; byte loads @0x033 signed -> 0xFFFFFF80; @0x033 unsigned -> 0x00000080; @0x030 signed -> 0x00000001; half load @0x030 signed -> 0x00007F01; half load @0x032 signed -> 0xFFFF80FF.
- Half store 0xBEEF @0x041 -> access_error pulse, stall 1 cycle, no mem_we or mem_re; word store @0x046 and size=11 requests -> same.
- Reset asserted in RMW of half store 0x1234 @0x052 over 0xCAFEF00D -> mem_we=0 during reset, word stays 0xCAFEF00D, outputs at reset values next cycle.
- Back-to-back word stores to 0x7FFC and 0x000 -> no stall, both words written, no wrap error.
